condicionador_botoes: RTL and testbench
=======================================

CONDICIONADOR_BOTOES -- requirements
Module: condicionador_botoes

Interface
REQ-001 Parameter: DEBOUNCE_CICLOS, default 50000, number of consecutive stable clock cycles needed to accept a new input level (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 Port: clock  input  1  system clock; every register SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset; the block SHALL be in reset while reset=0.
REQ-004 Port: botoes_brutos  input  4  raw, asynchronous, bouncing push-button levels; 1 = pressed.
REQ-005 Port: jogar_bruto  input  1  raw, asynchronous, bouncing start-button level; 1 = pressed.
REQ-006 Port: botoes  output  4  conditioned buttons to the game top-level botoes input; one-hot or 0000.
REQ-007 Port: jogar  output  1  one-cycle pulse to the game top-level jogar input.
REQ-008 Port: multiplos  output  1  level; 1 while two or more debounced buttons are pressed.
REQ-009 Port: db_botoes_estaveis  output  4  debug; the debounced button levels before the one-hot filter.

Function
REQ-010 Each of the 5 raw inputs SHALL pass through its own 2-flip-flop synchronizer before any other logic uses it.
REQ-011 Each input SHALL have an independent 4-state debounce FSM.
- ESTAVEL_0 -> CONFIRMA_1 when the synchronized value is 1.
- CONFIRMA_1 -> ESTAVEL_1 once the counter reaches DEBOUNCE_CICLOS-1 with the value still 1.
- CONFIRMA_1 -> ESTAVEL_0 immediately, with the counter cleared, if the value returns to 0.
- ESTAVEL_1, CONFIRMA_0 and the return path are symmetric.
REQ-012 Each debounce counter SHALL be $clog2(DEBOUNCE_CICLOS) bits wide, cleared on every entry to a CONFIRMA state, and SHALL never wrap.
REQ-013 A debounced level SHALL be 1 exactly in ESTAVEL_1 and CONFIRMA_0.
- A clean raw edge therefore reaches the debounced level after DEBOUNCE_CICLOS+2 clock cycles.
- Any glitch shorter than DEBOUNCE_CICLOS cycles SHALL produce no change.
REQ-014 db_botoes_estaveis SHALL equal the four debounced button levels.
REQ-015 When the popcount of db_botoes_estaveis is 0 or 1:
- botoes SHALL equal db_botoes_estaveis.
- multiplos SHALL be 0.
REQ-016 When the popcount is 2 or more:
- botoes SHALL be 0000.
- multiplos SHALL be 1.
- When the popcount drops back to 1, botoes SHALL show the remaining button in the same cycle.
REQ-017 jogar SHALL be 1 for exactly one cycle on the rising edge of the debounced start level; holding the button SHALL produce no further pulses.
REQ-018 botoes, multiplos and jogar SHALL be registered outputs (one cycle after the debounced levels) and SHALL have no combinational path from the inputs.
REQ-019 The button channels and the start channel SHALL be fully independent; simultaneous edges on all 5 inputs SHALL each be handled correctly.

Reset
REQ-020 While reset=0, the block SHALL immediately hold the following, independent of clock:
- all FSMs in ESTAVEL_0;
- all counters and synchronizer flops at 0;
- botoes=0000, jogar=0, multiplos=0, db_botoes_estaveis=0000.
REQ-021 Reset asserted mid-confirmation SHALL discard the partial count.
REQ-022 After release, a button already held SHALL be re-debounced in full, and its jogar pulse (if any) SHALL be issued only after that.

Configuration
REQ-023 The macro CONDICIONADOR_BOTOES_PULSO_EN SHALL control the botoes output mode.
- Defined: each botoes bit SHALL pulse for exactly one cycle when its filtered value (per REQ-015/016) rises 0->1, and SHALL be 0 otherwise.
- Undefined: botoes SHALL be the level behaviour of REQ-015/016.
- multiplos, jogar and db_botoes_estaveis SHALL be unaffected by the macro.

Verification (DEBOUNCE_CICLOS=4)
REQ-024 Clean press: botoes_brutos 0000->0010 held 20 cycles -> botoes=0010 appears 7 cycles after the edge (2 sync, 4 debounce, 1 output register) and stays 0010 until release+7 cycles.
REQ-025 Bounce: botoes_brutos[0] toggles 1,0,1,0 at 1-cycle intervals, then stays 1 -> botoes stays 0000 during the bounce, then becomes 0001 7 cycles after the final edge.
REQ-026 Multi-press: debounced 0001, then button 2 added -> botoes=0000 and multiplos=1; after button 0 is released -> botoes=0100 and multiplos=0.
REQ-027 Start: jogar_bruto held high 30 cycles -> jogar=1 for exactly 1 cycle, 7 cycles after the edge; a second press after release yields exactly 1 more pulse.
REQ-028 Reset mid-confirmation: reset=0 for 1 cycle, 3 cycles after a 0000->1000 edge with the button still held -> all outputs read 0 immediately; botoes=1000 appears 7 cycles after release.
REQ-029 With CONDICIONADOR_BOTOES_PULSO_EN defined: 0100 held 20 cycles -> botoes=0100 for exactly 1 cycle, then 0000.

Source files
------------

// File: rtl/condicionador_botoes.sv
// Button conditioner: per-input 2-FF synchronizer and debounce FSM, one-hot filter and start pulse.
// Optional macro CONDICIONADOR_BOTOES_PULSO_EN turns botoes into one-cycle rising-edge pulses.

module condicionador_botoes_canal #(
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic bruto_i,
  output logic nivel_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

  typedef enum logic [1:0] {
    ESTAVEL_0  = 2'd0,
    CONFIRMA_1 = 2'd1,
    ESTAVEL_1  = 2'd2,
    CONFIRMA_0 = 2'd3
  } estado_t;

  logic [1:0]    sync_q;
  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          nivel_q, nivel_d;
  logic          amostra;

  assign amostra = sync_q[1];
  assign cnt_inc = cnt_q + CW'(1);

  // Entering CONFIRMA already counts the first stable sample, so the switch
  // happens on the cycle the counter would reach DEBOUNCE_CICLOS-1.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    unique case (estado_q)
      ESTAVEL_0: begin
        if (amostra) begin
          estado_d = CONFIRMA_1;
          cnt_d    = '0;
        end
      end
      CONFIRMA_1: begin
        if (!amostra) begin
          estado_d = ESTAVEL_0;
          cnt_d    = '0;
        end else if (cnt_inc == CNT_FIM) begin
          estado_d = ESTAVEL_1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ESTAVEL_1: begin
        if (!amostra) begin
          estado_d = CONFIRMA_0;
          cnt_d    = '0;
        end
      end
      CONFIRMA_0: begin
        if (amostra) begin
          estado_d = ESTAVEL_1;
          cnt_d    = '0;
        end else if (cnt_inc == CNT_FIM) begin
          estado_d = ESTAVEL_0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        estado_d = ESTAVEL_0;
        cnt_d    = '0;
      end
    endcase
    nivel_d = (estado_d == ESTAVEL_1) || (estado_d == CONFIRMA_0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      estado_q <= ESTAVEL_0;
      cnt_q    <= '0;
      nivel_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], bruto_i};
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      nivel_q  <= nivel_d;
    end
  end

  assign nivel_o = nivel_q;

endmodule

module condicionador_botoes #(
  parameter int unsigned DEBOUNCE_CICLOS = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] botoes_brutos,
  input  logic       jogar_bruto,
  output logic [3:0] botoes,
  output logic       jogar,
  output logic       multiplos,
  output logic [3:0] db_botoes_estaveis
);

  localparam int unsigned NB = 4;
  localparam int unsigned PW = 3;

  logic [NB-1:0] nivel_botoes;
  logic          nivel_jogar;
  logic [PW-1:0] contagem;
  logic [NB-1:0] filtro;

  logic [NB-1:0] botoes_q, botoes_d;
  logic          multiplos_q, multiplos_d;
  logic          jogar_q, jogar_d;
  logic          jogar_ant_q;
`ifdef CONDICIONADOR_BOTOES_PULSO_EN
  logic [NB-1:0] filtro_ant_q;
`endif

  for (genvar i = 0; i < int'(NB); i++) begin : g_botao
    condicionador_botoes_canal #(
      .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_canal (
      .clock  (clock),
      .reset  (reset),
      .bruto_i(botoes_brutos[i]),
      .nivel_o(nivel_botoes[i])
    );
  end

  condicionador_botoes_canal #(
    .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
  ) u_canal_jogar (
    .clock  (clock),
    .reset  (reset),
    .bruto_i(jogar_bruto),
    .nivel_o(nivel_jogar)
  );

  always_comb begin
    contagem = '0;
    for (int i = 0; i < int'(NB); i++) begin
      contagem = contagem + PW'(nivel_botoes[i]);
    end
  end

  // One-hot filter: any simultaneous press masks all buttons.
  always_comb begin
    filtro      = '0;
    multiplos_d = 1'b0;
    if (contagem >= PW'(2)) begin
      multiplos_d = 1'b1;
    end else begin
      filtro = nivel_botoes;
    end
`ifdef CONDICIONADOR_BOTOES_PULSO_EN
    botoes_d = filtro & ~filtro_ant_q;
`else
    botoes_d = filtro;
`endif
    jogar_d = nivel_jogar & ~jogar_ant_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      botoes_q     <= '0;
      multiplos_q  <= 1'b0;
      jogar_q      <= 1'b0;
      jogar_ant_q  <= 1'b0;
`ifdef CONDICIONADOR_BOTOES_PULSO_EN
      filtro_ant_q <= '0;
`endif
    end else begin
      botoes_q     <= botoes_d;
      multiplos_q  <= multiplos_d;
      jogar_q      <= jogar_d;
      jogar_ant_q  <= nivel_jogar;
`ifdef CONDICIONADOR_BOTOES_PULSO_EN
      filtro_ant_q <= filtro;
`endif
    end
  end

  assign botoes             = botoes_q;
  assign multiplos          = multiplos_q;
  assign jogar              = jogar_q;
  assign db_botoes_estaveis = nivel_botoes;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with DEBOUNCE_CICLOS=4: directed scenarios plus random stimulus vs. a window-based model.

module tb_condicionador_botoes;

  localparam int unsigned N = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes_brutos;
  logic       jogar_bruto;
  logic [3:0] botoes;
  logic       jogar;
  logic       multiplos;
  logic [3:0] db_botoes_estaveis;

  int npass = 0;
  int ntot  = 0;

  always #5 clock = ~clock;

  condicionador_botoes #(
    .DEBOUNCE_CICLOS(N)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .botoes_brutos     (botoes_brutos),
    .jogar_bruto       (jogar_bruto),
    .botoes            (botoes),
    .jogar             (jogar),
    .multiplos         (multiplos),
    .db_botoes_estaveis(db_botoes_estaveis)
  );

  // Model: a level flips once the last N synchronized samples all disagree with it.
  bit         d1 [5];
  bit         d2 [5];
  bit         jan [5][N];
  int         nval [5];
  bit         lvl [5];
  logic [3:0] db_prev;
  bit         st_prev;
  logic [3:0] exp_db, exp_botoes;
  bit         exp_mult, exp_jogar;

  function automatic logic [3:0] filt(input logic [3:0] v);
    return ($countones(v) <= 1) ? v : 4'b0000;
  endfunction

  function automatic logic [3:0] lvl_botoes();
    return {lvl[3], lvl[2], lvl[1], lvl[0]};
  endfunction

  task automatic modelo_reset();
    for (int c = 0; c < 5; c++) begin
      d1[c] = 0; d2[c] = 0; nval[c] = 0; lvl[c] = 0;
      for (int k = 0; k < int'(N); k++) jan[c][k] = 0;
    end
    db_prev = '0; st_prev = 0;
    exp_db = '0; exp_botoes = '0; exp_mult = 0; exp_jogar = 0;
  endtask

  task automatic modelo_borda(input logic [3:0] b, input logic j);
    bit raw [5];
    bit samp;
    bit todos;
    logic [3:0] db_now;
    raw[0] = b[0]; raw[1] = b[1]; raw[2] = b[2]; raw[3] = b[3]; raw[4] = j;
    db_now = lvl_botoes();
`ifdef CONDICIONADOR_BOTOES_PULSO_EN
    exp_botoes = filt(db_now) & ~filt(db_prev);
`else
    exp_botoes = filt(db_now);
`endif
    exp_mult  = ($countones(db_now) >= 2);
    exp_jogar = lvl[4] && !st_prev;
    db_prev   = db_now;
    st_prev   = lvl[4];
    for (int c = 0; c < 5; c++) begin
      samp  = d2[c];
      d2[c] = d1[c];
      d1[c] = raw[c];
      for (int k = 0; k < int'(N) - 1; k++) jan[c][k] = jan[c][k+1];
      jan[c][N-1] = samp;
      if (nval[c] < int'(N)) nval[c]++;
      todos = (nval[c] == int'(N));
      for (int k = 0; k < int'(N); k++) if (jan[c][k] == lvl[c]) todos = 0;
      if (todos) lvl[c] = !lvl[c];
    end
    exp_db = lvl_botoes();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic ciclo(input logic [3:0] b, input logic j);
    @(negedge clock);
    botoes_brutos = b;
    jogar_bruto   = j;
    @(posedge clock);
    modelo_borda(b, j);
    #1;
    chk("model_db", db_botoes_estaveis, exp_db);
    chk("model_botoes", botoes, exp_botoes);
    chk("model_multiplos", {3'b000, multiplos}, {3'b000, exp_mult});
    chk("model_jogar", {3'b000, jogar}, {3'b000, exp_jogar});
  endtask

  // Called just after a rising edge; holds reset across exactly one edge.
  task automatic aplica_reset();
    reset = 1'b0;
    #1;
    chk("rst_botoes", botoes, 4'b0000);
    chk("rst_db", db_botoes_estaveis, 4'b0000);
    chk("rst_multiplos", {3'b000, multiplos}, 4'b0000);
    chk("rst_jogar", {3'b000, jogar}, 4'b0000);
    @(posedge clock);
    #1;
    reset = 1'b1;
    modelo_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulsos;
    int hold;
    logic [3:0] rb;
    logic rj;
    botoes_brutos = '0;
    jogar_bruto   = 1'b0;
    aplica_reset();

`ifndef CONDICIONADOR_BOTOES_PULSO_EN
    // Clean press then release: level visible 7 cycles after each edge.
    for (int i = 1; i <= 20; i++) begin
      ciclo(4'b0010, 1'b0);
      chk("press_lat", botoes, (i >= 7) ? 4'b0010 : 4'b0000);
    end
    for (int i = 1; i <= 10; i++) begin
      ciclo(4'b0000, 1'b0);
      chk("release_lat", botoes, (i >= 7) ? 4'b0000 : 4'b0010);
    end

    // Bounce on button 0, final edge at step 5.
    for (int i = 1; i <= 14; i++) begin
      ciclo((i == 2 || i == 4) ? 4'b0000 : 4'b0001, 1'b0);
      chk("bounce", botoes, (i >= 11) ? 4'b0001 : 4'b0000);
    end
    for (int i = 0; i < 10; i++) ciclo(4'b0000, 1'b0);

    // Multi-press then partial release.
    for (int i = 0; i < 8; i++) ciclo(4'b0001, 1'b0);
    chk("multi_one", botoes, 4'b0001);
    for (int i = 0; i < 8; i++) ciclo(4'b0101, 1'b0);
    chk("multi_two_botoes", botoes, 4'b0000);
    chk("multi_two_flag", {3'b000, multiplos}, 4'b0001);
    for (int i = 0; i < 8; i++) ciclo(4'b0100, 1'b0);
    chk("multi_left_botoes", botoes, 4'b0100);
    chk("multi_left_flag", {3'b000, multiplos}, 4'b0000);
    for (int i = 0; i < 8; i++) ciclo(4'b0000, 1'b0);
`else
    for (int i = 1; i <= 20; i++) begin
      ciclo(4'b0100, 1'b0);
      chk("pulse_mode", botoes, (i == 7) ? 4'b0100 : 4'b0000);
    end
    for (int i = 0; i < 10; i++) ciclo(4'b0000, 1'b0);
`endif

    // Start button: one pulse per press, 7 cycles after the edge.
    for (int r = 0; r < 2; r++) begin
      pulsos = 0;
      for (int i = 1; i <= 30; i++) begin
        ciclo(4'b0000, 1'b1);
        if (jogar) pulsos++;
        chk("jogar_pos", {3'b000, jogar}, (i == 7) ? 4'b0001 : 4'b0000);
      end
      chk("jogar_count", 4'(pulsos), 4'd1);
      for (int i = 0; i < 10; i++) ciclo(4'b0000, 1'b0);
    end

    // Reset mid-confirmation with button 3 held.
    for (int i = 0; i < 3; i++) ciclo(4'b1000, 1'b0);
    aplica_reset();
    for (int i = 1; i <= 10; i++) begin
      ciclo(4'b1000, 1'b0);
`ifndef CONDICIONADOR_BOTOES_PULSO_EN
      chk("post_reset", botoes, (i >= 7) ? 4'b1000 : 4'b0000);
`else
      chk("post_reset", botoes, (i == 7) ? 4'b1000 : 4'b0000);
`endif
    end

    // Random segments, with a reset while levels are likely active.
    for (int s = 0; s < 90; s++) begin
      rb   = 4'($urandom_range(0, 15));
      rj   = 1'($urandom_range(0, 1));
      hold = int'($urandom_range(1, 8));
      for (int i = 0; i < hold; i++) ciclo(rb, rj);
      if (s == 45) aplica_reset();
    end
    for (int i = 0; i < 12; i++) ciclo(4'b0000, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
